if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32I core.
- Owns the program counter and drives the combinational instruction ROM's address and chip-enable.
- Captures the returned instruction with its PC into the IF/ID pipeline register for the decode stage.
- Handles the pipeline stall from ID, branch/jump redirect from EX, and a global flush.

---
 rtl/if_fetch_stage.sv | 103 ++++++++++
 tb/tb_if_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM,
// and registers the fetched instruction with its PC into the IF/ID pipeline register.
module if_fetch_stage #(
   parameter int unsigned           ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0,
   parameter logic [31:0]           NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]       rom_inst_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [31:0]       id_inst_o,
   output logic              id_valid_o,
   output logic              misalign_o
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic              ce_q, ce_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [31:0]       id_inst_q, id_inst_d;
   logic              id_valid_q, id_valid_d;
   logic              misalign_q, misalign_d;

   logic              take_target;
   logic [ADDR_W-1:0] target;

   // Flush outranks redirect; both outrank stall. Nothing is steered while ce is low.
   always_comb begin
      take_target = 1'b0;
      target      = '0;
      if (ce_q) begin
         if (flush_i) begin
            take_target = 1'b1;
            target      = flush_pc_i;
         end else if (redirect_i) begin
            take_target = 1'b1;
            target      = redirect_pc_i;
         end
      end
   end

   always_comb begin
      ce_d       = 1'b1;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      misalign_d = 1'b0;

      if (!ce_q) begin
         id_pc_d    = pc_q;
         id_inst_d  = NOP_INST;
         id_valid_d = 1'b0;
      end else if (take_target) begin
         // The target is forced word-aligned; the dropped low bits are only reported.
         pc_d       = {target[ADDR_W-1:2], 2'b00};
         misalign_d = |target[1:0];
         id_pc_d    = pc_q;
         id_inst_d  = NOP_INST;
         id_valid_d = 1'b0;
      end else if (!stall_i) begin
         pc_d       = pc_q + PC_STEP;
         id_pc_d    = pc_q;
         id_inst_d  = rom_inst_i;
         id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_q       <= 1'b0;
         pc_q       <= RESET_PC;
         id_pc_q    <= RESET_PC;
         id_inst_q  <= NOP_INST;
         id_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         ce_q       <= ce_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign rom_ce_o   = ce_q;
   assign rom_addr_o = pc_q;
   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign id_valid_o = id_valid_q;
   assign misalign_o = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized control traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] flush_pc_i = '0, redirect_pc_i = '0;
   logic        rom_ce_o, id_valid_o, misalign_o;
   logic [31:0] rom_addr_o, rom_inst_i, id_pc_o, id_inst_o;

   logic [31:0] rom_mem [64];
   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit          m_ce, m_valid, m_mis;
   logic [31:0] m_pc, m_idpc, m_idinst;

   always #5 clk = ~clk;

   assign rom_inst_i = rom_mem[rom_addr_o[7:2]];

   if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
      .flush_pc_i(flush_pc_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
      .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
      .misalign_o(misalign_o)
   );

   task automatic model_reset();
      m_ce = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'h0; m_idpc = 32'h0; m_idinst = NOP;
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      bit          jump;
      jump = 0;
      tgt  = '0;
      if (!m_ce) begin
         m_ce = 1; m_valid = 0; m_idinst = NOP; m_mis = 0;
      end else begin
         if (flush_i) begin jump = 1; tgt = flush_pc_i; end
         else if (redirect_i) begin jump = 1; tgt = redirect_pc_i; end
         if (jump) begin
            m_mis = (tgt % 4) != 0;
            m_pc = tgt - (tgt % 4);
            m_valid = 0; m_idinst = NOP;
         end else if (stall_i) begin
            m_mis = 0;
         end else begin
            m_mis = 0;
            m_idpc = m_pc; m_idinst = rom_mem[(m_pc / 4) % 64]; m_valid = 1;
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_i = 0; flush_i = 0; redirect_i = 0; flush_pc_i = '0; redirect_pc_i = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic load_program();
      for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
      rom_mem[0] = 32'h0200_0193;
      rom_mem[1] = 32'h0400_0213;
      rom_mem[2] = 32'h0211_8193;
      rom_mem[3] = 32'h0401_8213;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      model_reset();
      #1;
      n_cmp++; if (rom_ce_o !== 1'b0) begin n_bad++; $display("FAIL reset_ce: got %b want 0", rom_ce_o); end
      n_cmp++; if (rom_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", rom_addr_o); end
      n_cmp++; if (id_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_idpc: got %h want 0", id_pc_o); end
      n_cmp++; if (id_inst_o !== NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", id_inst_o, NOP); end
      n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
      n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %b want 0", misalign_o); end
   endtask

   task automatic test_program();
      apply_reset();
      cyc();
      n_cmp++; if (rom_ce_o !== 1'b1) begin n_bad++; $display("FAIL e1_ce: got %b want 1", rom_ce_o); end
      n_cmp++; if (rom_addr_o !== 32'h0) begin n_bad++; $display("FAIL e1_pc: got %h want 0", rom_addr_o); end
      n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL e1_valid: got %b want 0", id_valid_o); end
      cyc();
      n_cmp++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0200_0193 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL e2_id: got {%h,%h,%b} want {0,02000193,1}", id_pc_o, id_inst_o, id_valid_o); end
      cyc();
      n_cmp++; if (id_pc_o !== 32'h4 || id_inst_o !== 32'h0400_0213 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL e3_id: got {%h,%h,%b} want {4,04000213,1}", id_pc_o, id_inst_o, id_valid_o); end
      cyc();
      cyc();
      n_cmp++; if (id_pc_o !== 32'hC || id_inst_o !== 32'h0401_8213 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL e5_id: got {%h,%h,%b} want {c,04018213,1}", id_pc_o, id_inst_o, id_valid_o); end
      n_cmp++; if (rom_addr_o !== 32'h10) begin n_bad++; $display("FAIL e5_pc: got %h want 10", rom_addr_o); end
   endtask

   task automatic test_stall();
      apply_reset();
      repeat (3) cyc();
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++; if (id_pc_o !== 32'h4 || id_inst_o !== 32'h0400_0213 || id_valid_o !== 1'b1 || rom_addr_o !== 32'h8) begin
            n_bad++; $display("FAIL stall_hold%0d: got {%h,%h,%b} pc=%h want {4,04000213,1} pc=8", i, id_pc_o, id_inst_o, id_valid_o, rom_addr_o); end
      end
      stall_i = 0;
      cyc();
      n_cmp++; if (id_pc_o !== 32'h8 || id_inst_o !== 32'h0211_8193 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL stall_release: got {%h,%h,%b} want {8,02118193,1}", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_redirect();
      apply_reset();
      repeat (4) cyc();
      redirect_i = 1; redirect_pc_i = 32'h0;
      cyc();
      redirect_i = 0;
      n_cmp++; if (rom_addr_o !== 32'h0 || id_valid_o !== 1'b0 || id_inst_o !== NOP) begin
         n_bad++; $display("FAIL redir_bubble: got pc=%h v=%b inst=%h want pc=0 v=0 inst=00000013", rom_addr_o, id_valid_o, id_inst_o); end
      cyc();
      n_cmp++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0200_0193 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL redir_target: got {%h,%h,%b} want {0,02000193,1}", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_priority();
      apply_reset();
      repeat (2) cyc();
      stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h20;
      cyc();
      n_cmp++; if (rom_addr_o !== 32'h20 || id_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL redir_over_stall: got pc=%h v=%b want pc=20 v=0", rom_addr_o, id_valid_o); end
      stall_i = 0; flush_i = 1; flush_pc_i = 32'h8; redirect_pc_i = 32'h4;
      cyc();
      idle_inputs();
      n_cmp++; if (rom_addr_o !== 32'h8 || id_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL flush_over_redir: got pc=%h v=%b want pc=8 v=0", rom_addr_o, id_valid_o); end
      cyc();
      n_cmp++; if (id_pc_o !== 32'h8 || id_inst_o !== 32'h0211_8193 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL flush_target: got {%h,%h,%b} want {8,02118193,1}", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_misalign();
      apply_reset();
      repeat (2) cyc();
      redirect_i = 1; redirect_pc_i = 32'h6;
      cyc();
      redirect_i = 0;
      n_cmp++; if (rom_addr_o !== 32'h4 || misalign_o !== 1'b1) begin
         n_bad++; $display("FAIL mis_pulse: got pc=%h mis=%b want pc=4 mis=1", rom_addr_o, misalign_o); end
      cyc();
      n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL mis_drop: got %b want 0", misalign_o); end
      flush_i = 1; flush_pc_i = 32'h13;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++; if (misalign_o !== 1'b1 || rom_addr_o !== 32'h10) begin
            n_bad++; $display("FAIL mis_cont%0d: got mis=%b pc=%h want mis=1 pc=10", i, misalign_o, rom_addr_o); end
      end
      idle_inputs();
   endtask

   task automatic test_wrap_and_async_reset();
      apply_reset();
      cyc();
      flush_i = 1; flush_pc_i = 32'hFFFF_FFFC;
      cyc();
      flush_i = 0;
      n_cmp++; if (rom_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_load: got %h want fffffffc", rom_addr_o); end
      cyc();
      n_cmp++; if (rom_addr_o !== 32'h0 || id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== rom_mem[63] || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL wrap_step: got pc=%h id={%h,%h,%b} want pc=0 id={fffffffc,%h,1}", rom_addr_o, id_pc_o, id_inst_o, id_valid_o, rom_mem[63]); end
      repeat (2) cyc();
      redirect_i = 1; redirect_pc_i = 32'h2A; stall_i = 1;
      cyc();
      #2 rst_n = 0;
      idle_inputs();
      model_reset();
      #1;
      n_cmp++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || id_pc_o !== 32'h0 || id_inst_o !== NOP || id_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: got ce=%b pc=%h id={%h,%h,%b} mis=%b want all reset", rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, misalign_o); end
      @(negedge clk);
      rst_n = 1;
      cyc();
      n_cmp++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL restart_e1: got ce=%b pc=%h v=%b want ce=1 pc=0 v=0", rom_ce_o, rom_addr_o, id_valid_o); end
      cyc();
      n_cmp++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0200_0193 || id_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL restart_e2: got {%h,%h,%b} want {0,02000193,1}", id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         stall_i       = ($urandom_range(0, 3) == 0);
         redirect_i    = ($urandom_range(0, 5) == 0);
         flush_i       = ($urandom_range(0, 11) == 0);
         redirect_pc_i = $urandom;
         flush_pc_i    = $urandom;
         cyc();
         n_cmp++; if (rom_ce_o !== m_ce || rom_addr_o !== m_pc || misalign_o !== m_mis) begin
            n_bad++; $display("FAIL rand_ctl%0d: got ce=%b pc=%h mis=%b want ce=%b pc=%h mis=%b", i, rom_ce_o, rom_addr_o, misalign_o, m_ce, m_pc, m_mis); end
         n_cmp++; if (id_valid_o !== m_valid || id_inst_o !== m_idinst || (m_valid && id_pc_o !== m_idpc)) begin
            n_bad++; $display("FAIL rand_id%0d: got {%h,%h,%b} want {%h,%h,%b}", i, id_pc_o, id_inst_o, id_valid_o, m_idpc, m_idinst, m_valid); end
      end
      idle_inputs();
   endtask

   initial begin
      load_program();
      model_reset();
      test_reset();
      test_program();
      test_stall();
      test_redirect();
      test_priority();
      test_misalign();
      test_wrap_and_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
